data_memory_delayed: RTL and testbench
======================================

# data_memory_delayed

Multi-cycle data memory for the MEM stage of the pipelined MIPS core, sitting directly downstream of the ALU. The EX/MEM register delivers the ALU result as the byte address (`ALUOutM`). The block models a slow RAM with a fixed, parameterised access latency. While an access is in flight it asserts a stall, so the hazard unit freezes the pipeline until read data is valid or the write has committed.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, at least 4.
- `LATENCY`, 4: cycles from request acceptance to data valid; at least 2.
- `clk` in 1: sole clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemReadM` in 1: load request for the instruction currently in MEM.
- `MemWriteM` in 1: store request for the instruction currently in MEM.
- `ALUOutM` in 32: byte address taken from the ALU result.
- `WriteDataM` in 32: store data.
- `ReadDataM` out 32: load data, registered.
- `MemStallM` out 1: high while the pipeline must hold the current MEM instruction.
- `MemDoneM` out 1: one-cycle pulse in the cycle that read data is valid or the write has completed.

## Operation
- Word index = `ALUOutM[log2(DEPTH)+1:2]`.
  - `ALUOutM[1:0]` is ignored (no misalignment trap).
  - Bits above the index are ignored, so addresses wrap modulo `DEPTH` words.
- Request (req) = `MemReadM | MemWriteM`.
- State machine with three states: IDLE, BUSY, DONE.
- IDLE:
  - If req is high: latch the index, `WriteDataM`, and both request bits; load the counter with `LATENCY-1`; go to BUSY.
  - If req is low: stay in IDLE.
- BUSY:
  - If counter equals 1: perform the access at this edge and go to DONE.
  - Otherwise: decrement the counter.
  - Inputs are ignored while in BUSY; latched values are used.
- Access:
  - On a write, `mem[idx] <= latched data`.
  - On a read, `ReadDataM <= mem[idx]`.
  - If both read and write are latched: the write commits, and `ReadDataM` captures the pre-write contents.
- DONE: `MemDoneM` = 1, `MemStallM` = 0. Go to IDLE unconditionally; req is not sampled in DONE, because the instruction in MEM is the one just served.
- `MemStallM` = (IDLE and req) or BUSY. It is combinational, so the stall is visible in the same cycle the request appears.
- `ReadDataM` holds its last value in every cycle other than the read-completion edge.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `ReadDataM` = 0, `MemStallM` = 0 (given req is low), `MemDoneM` = 0.
  - Memory contents are not cleared by reset.
- Request first seen in cycle 0 (IDLE):
  - `MemStallM` is high in cycles 0 through `LATENCY-1`.
  - DONE occurs in cycle `LATENCY`; `ReadDataM` and `MemDoneM` are valid there.
  - The MEM/WB register captures `ReadDataM` at the end of cycle `LATENCY`.
- Total occupancy is `LATENCY+1` cycles per access. A back-to-back request is accepted in cycle `LATENCY+1` at the earliest.
- A non-memory instruction in IDLE causes no stall and no state change.
- Reset asserted mid-access:
  - State returns to IDLE immediately and `MemStallM` drops.
  - A pending write is discarded (memory unchanged).
  - `ReadDataM` clears to 0.
- `LATENCY`=2 edge case: cycle 0 IDLE, cycle 1 BUSY with counter = 1, cycle 2 DONE.

## Test plan
- Reset with req low:
  - Required: `ReadDataM`=0, `MemStallM`=0, `MemDoneM`=0.
  - Then hold `MemReadM`=0 and `MemWriteM`=0 for 10 cycles: stall never asserts.
- Store then load, `LATENCY`=4:
  - Stimulus: `MemWriteM`=1, `ALUOutM`=0x10, `WriteDataM`=0xDEADBEEF.
  - Required: stall high for 4 cycles, `MemDoneM` pulse in cycle 4.
  - Then `MemReadM`=1 at 0x10. Required: `ReadDataM`=0xDEADBEEF in cycle 4 of the load, and the stall is exactly 4 cycles.
- Wrap and alignment, `DEPTH`=64:
  - Stimulus: store 0x12345678 at 0x103.
  - Required: a load from 0x000 returns 0x12345678 (index 0 reached through both wrap and ignored low bits).
- Simultaneous read and write:
  - Stimulus: word 5 holds 0xAAAA0000; request read and write at 0x14 with data 0x5555FFFF.
  - Required: `ReadDataM`=0xAAAA0000; a subsequent load from 0x14 returns 0x5555FFFF.
- Input change during BUSY:
  - Stimulus: change `ALUOutM` and `WriteDataM` in cycle 2 of a store to 0x20.
  - Required: the stored value and address are the ones latched in cycle 0.
- Reset mid-access:
  - Stimulus: assert reset in cycle 2 of a store of 0xCAFEF00D to 0x30, where the word previously held 0x11111111.
  - Required: stall drops asynchronously, and after release a load from 0x30 returns 0x11111111.

Source files
------------

// File: rtl/data_memory_delayed.sv
`default_nettype none
// ============================================================================
// data_memory_delayed : multi-cycle MEM-stage data RAM with fixed LATENCY,
//                       stalling the pipeline while an access is in flight.
// Revision 1.0
// ============================================================================
module data_memory_delayed #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MemDoneM
);
    localparam int               IDX_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             rd_q;
    logic             wr_q;
    logic             done_q;
    logic [31:0]      mem_q [DEPTH];

    logic             w_req;
    logic             w_access;
    logic [IDX_W-1:0] w_idx;
    logic             w_unused_addr;

    assign w_req         = MemReadM | MemWriteM;
    assign w_idx         = ALUOutM[IDX_W+1:2];
    assign w_unused_addr = ^{ALUOutM[31:IDX_W+2], ALUOutM[1:0]};
    assign w_access      = (state_q == ST_BUSY) && (cnt_q == CNT_ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        idx_q   <= w_idx;
                        wdata_q <= WriteDataM;
                        rd_q    <= MemReadM;
                        wr_q    <= MemWriteM;
                        cnt_q   <= CNT_LOAD;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == CNT_ONE) begin
                        // Non-blocking read sees the pre-write word on a read+write access.
                        if (rd_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage is not reset; an aborted access never reaches this write because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (w_access && wr_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ReadDataM = rdata_q;
    assign MemDoneM  = done_q;
    assign MemStallM = ((state_q == ST_IDLE) && w_req) || (state_q == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_data_memory_delayed.sv
`default_nettype none
// ============================================================================
// tb_data_memory_delayed : self-checking bench for data_memory_delayed.
// Revision 1.0
// ============================================================================
module tb_data_memory_delayed;
    localparam int          DEPTH     = 64;
    localparam int          LATENCY   = 4;
    localparam logic [31:0] EXP_STALL = (32'd1 << LATENCY) - 32'd1;
    localparam logic [31:0] EXP_DONE  = 32'd1 << LATENCY;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStallM;
    logic        MemDoneM;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rdata;

    data_memory_delayed #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .MemStallM  (MemStallM),
        .MemDoneM   (MemDoneM)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Drives one access starting in the next cycle and records what the DUT shows
    // in each cycle 0..LATENCY; the model supplies the expected read values.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int alt_cycle,
                              input logic [31:0] alt_addr, input logic [31:0] alt_data,
                              output logic [31:0] o_stall, output logic [31:0] o_done,
                              output logic [31:0] o_hold, output logic [31:0] o_rdata,
                              output logic [31:0] e_hold, output logic [31:0] e_rdata);
        int idx;
        idx     = int'((addr / 4) % DEPTH);
        e_hold  = exp_rdata;
        e_rdata = rd ? model_mem[idx] : exp_rdata;
        o_stall = '0;
        o_done  = '0;
        o_hold  = '0;
        o_rdata = '0;
        @(posedge clk);
        #1;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUOutM    = addr;
        WriteDataM = wdata;
        for (int k = 0; k <= LATENCY; k++) begin
            @(negedge clk);
            o_stall[k] = MemStallM;
            o_done[k]  = MemDoneM;
            if (k == LATENCY - 1) o_hold = ReadDataM;
            if (k == LATENCY) o_rdata = ReadDataM;
            if (k == alt_cycle) begin
                ALUOutM    = alt_addr;
                WriteDataM = alt_data;
            end
        end
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        if (wr) model_mem[idx] = wdata;
        exp_rdata = e_rdata;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ReadDataM !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want %h", ReadDataM, 32'h0); end
        checks++;
        if (MemStallM !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", MemStallM); end
        checks++;
        if (MemDoneM !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", MemDoneM); end
        reset = 1'b1;
        exp_rdata = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (MemStallM !== 1'b0 || MemDoneM !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_stall: cycle %0d stall=%b done=%b want 0/0", i, MemStallM, MemDoneM);
            end
        end
    endtask

    task automatic test_fill;
        logic [31:0] st, dn, hd, rdv, eh, er;
        for (int i = 0; i < DEPTH; i++) begin
            run_access(1'b0, 1'b1, 32'(i * 4), $urandom, -1, '0, '0, st, dn, hd, rdv, eh, er);
            checks++;
            if (st !== EXP_STALL || dn !== EXP_DONE) begin
                failures++;
                $display("FAIL fill_timing: word %0d stall=%h done=%h want %h/%h", i, st, dn, EXP_STALL, EXP_DONE);
            end
        end
    endtask

    task automatic test_store_load;
        logic [31:0] st, dn, hd, rdv, eh, er;
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (st !== EXP_STALL) begin failures++; $display("FAIL store_stall: got %h want %h", st, EXP_STALL); end
        checks++;
        if (dn !== EXP_DONE) begin failures++; $display("FAIL store_done: got %h want %h", dn, EXP_DONE); end
        run_access(1'b1, 1'b0, 32'h10, 32'h0, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (st !== EXP_STALL) begin failures++; $display("FAIL load_stall: got %h want %h", st, EXP_STALL); end
        checks++;
        if (dn !== EXP_DONE) begin failures++; $display("FAIL load_done: got %h want %h", dn, EXP_DONE); end
        checks++;
        if (rdv !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data: got %h want %h", rdv, 32'hDEADBEEF); end
        checks++;
        if (hd !== eh) begin failures++; $display("FAIL load_hold: got %h want %h", hd, eh); end
    endtask

    task automatic test_wrap;
        logic [31:0] st, dn, hd, rdv, eh, er;
        run_access(1'b0, 1'b1, 32'h103, 32'h12345678, -1, '0, '0, st, dn, hd, rdv, eh, er);
        run_access(1'b1, 1'b0, 32'h000, 32'h0, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (rdv !== 32'h12345678) begin failures++; $display("FAIL wrap_data: got %h want %h", rdv, 32'h12345678); end
    endtask

    task automatic test_simultaneous;
        logic [31:0] st, dn, hd, rdv, eh, er;
        run_access(1'b0, 1'b1, 32'h14, 32'hAAAA0000, -1, '0, '0, st, dn, hd, rdv, eh, er);
        run_access(1'b1, 1'b1, 32'h14, 32'h5555FFFF, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (rdv !== 32'hAAAA0000) begin failures++; $display("FAIL rw_old_data: got %h want %h", rdv, 32'hAAAA0000); end
        run_access(1'b1, 1'b0, 32'h14, 32'h0, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (rdv !== 32'h5555FFFF) begin failures++; $display("FAIL rw_new_data: got %h want %h", rdv, 32'h5555FFFF); end
    endtask

    task automatic test_busy_change;
        logic [31:0] st, dn, hd, rdv, eh, er;
        run_access(1'b0, 1'b1, 32'h24, 32'h0BADF00D, -1, '0, '0, st, dn, hd, rdv, eh, er);
        run_access(1'b0, 1'b1, 32'h20, 32'h600DCAFE, 2, 32'h24, 32'hFFFFFFFF, st, dn, hd, rdv, eh, er);
        checks++;
        if (st !== EXP_STALL) begin failures++; $display("FAIL busy_change_stall: got %h want %h", st, EXP_STALL); end
        run_access(1'b1, 1'b0, 32'h20, 32'h0, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (rdv !== 32'h600DCAFE) begin failures++; $display("FAIL busy_change_data: got %h want %h", rdv, 32'h600DCAFE); end
        run_access(1'b1, 1'b0, 32'h24, 32'h0, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (rdv !== 32'h0BADF00D) begin failures++; $display("FAIL busy_change_other: got %h want %h", rdv, 32'h0BADF00D); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] st, dn, hd, rdv, eh, er;
        run_access(1'b0, 1'b1, 32'h30, 32'h11111111, -1, '0, '0, st, dn, hd, rdv, eh, er);
        run_access(1'b1, 1'b0, 32'h30, 32'h0, -1, '0, '0, st, dn, hd, rdv, eh, er);
        @(posedge clk);
        #1;
        MemWriteM = 1'b1; ALUOutM = 32'h30; WriteDataM = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        checks++;
        if (MemStallM !== 1'b1) begin failures++; $display("FAIL abort_pre_stall: got %b want 1", MemStallM); end
        reset = 1'b0;
        MemWriteM = 1'b0;
        #1;
        checks++;
        if (MemStallM !== 1'b0) begin failures++; $display("FAIL abort_stall: got %b want 0", MemStallM); end
        checks++;
        if (ReadDataM !== 32'h0) begin failures++; $display("FAIL abort_rdata: got %h want %h", ReadDataM, 32'h0); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_rdata = '0;
        run_access(1'b1, 1'b0, 32'h30, 32'h0, -1, '0, '0, st, dn, hd, rdv, eh, er);
        checks++;
        if (rdv !== 32'h11111111) begin failures++; $display("FAIL abort_mem: got %h want %h", rdv, 32'h11111111); end
    endtask

    task automatic test_random;
        logic [31:0] st, dn, hd, rdv, eh, er;
        int op;
        int gap;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 2);
            run_access(op != 1, op != 0, $urandom, $urandom, $urandom_range(1, LATENCY - 1),
                       $urandom, $urandom, st, dn, hd, rdv, eh, er);
            checks++;
            if (st !== EXP_STALL || dn !== EXP_DONE) begin
                failures++;
                $display("FAIL rand_timing: op %0d stall=%h done=%h want %h/%h", n, st, dn, EXP_STALL, EXP_DONE);
            end
            checks++;
            if (hd !== eh) begin failures++; $display("FAIL rand_hold: op %0d got %h want %h", n, hd, eh); end
            checks++;
            if (rdv !== er) begin failures++; $display("FAIL rand_rdata: op %0d got %h want %h", n, rdv, er); end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (MemStallM !== 1'b0 || ReadDataM !== exp_rdata) begin
                    failures++;
                    $display("FAIL rand_idle: op %0d stall=%b rdata=%h want 0/%h", n, MemStallM, ReadDataM, exp_rdata);
                end
            end
        end
    endtask

    initial begin
        exp_rdata = '0;
        test_reset();
        test_fill();
        test_store_load();
        test_wrap();
        test_simultaneous();
        test_busy_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
